memory_access: RTL and testbench
================================

MEMORY_ACCESS -- requirements
Module: memory_access

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk and rst.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk in 1: clock, rising edge.
- rst in 1: async active-high reset.
- exec_mem_valid in 1: an op is present.
- exec_mem_writeback, exec_mem_link in 1: register write; link write of pc+4.
- exec_mem_mem_w, exec_mem_mem_r, exec_mem_mem_rdu in 1: store; load; unsigned load.
- exec_mem_mem_byte, exec_mem_mem_hwrd, exec_mem_mem_wrd in 1: access size.
- exec_mem_rd in 6: destination register.
- exec_mem_alu_result in 32: result or byte address.
- exec_mem_mem_wdata in 32: store data, low bits.
- exec_mem_pc4 in 32: link value.
- exec_mem_brnch_taken in 1 and exec_mem_bta in 32: branch resolution.
- dmem_req, dmem_we out 1: request; write.
- dmem_addr out 32: word-aligned address.
- dmem_wdata out 32: lane-replicated data.
- dmem_be out 4: byte enables.
- dmem_ack in 1, dmem_rdata in 32: completion; read word.
- mem_stall out 1: upstream holds all exec_mem_* inputs.
- mem_fetch_redirect out 1, mem_fetch_target out 32: redirect pulse and target.
- mem_misaligned out 1: one-cycle fault pulse.
- mem_wb_valid, mem_wb_writeback out 1; mem_wb_rd out 6; mem_wb_result out 32.

Function
REQ-003 The FSM SHALL have states IDLE and ACCESS.
REQ-004 Memory op = valid & (mem_r | mem_w); if both flags are set, it SHALL act as a store only.
REQ-005 Size SHALL follow priority wrd > hwrd > byte; no flag set SHALL mean word.
REQ-006 Misaligned = hwrd & addr[0], or word & addr[1:0] != 0. A misaligned op SHALL issue no request, SHALL pulse mem_misaligned on the next edge, SHALL produce mem_wb_valid=0, and SHALL not stall.
REQ-007 IDLE with an aligned memory op:
- latch address, be, wdata, we, size, rdu, rd and writeback;
- drive mem_stall=1 combinationally;
- go to ACCESS; next mem_wb_valid=0.
REQ-008 ACCESS: dmem_req=1 with all dmem_* outputs registered and stable until the ack cycle.
REQ-009 ACCESS with dmem_ack=1:
- mem_stall=0 in the same cycle;
- on the edge: mem_wb_valid=1, mem_wb_writeback = latched writeback & ~we, result = aligned load data (0 for stores);
- return to IDLE, so a new op is accepted on the following cycle.
REQ-010 ACCESS with dmem_ack=0: mem_stall=1 and all state held; no timeout.
REQ-011 Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'b1111. dmem_addr = {addr[31:2],2'b00}.
REQ-012 Store data: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
REQ-013 Load data: rdata >> 8*addr[1:0], truncated to size, then zero-extended if rdu, else sign-extended.
REQ-014 Non-memory valid op in IDLE: one-cycle latency with no stall; mem_wb_result = link ? pc4 : alu_result; mem_wb_valid=1; writeback passed through.
REQ-015 Redirect: on the edge accepting any valid op with brnch_taken=1, pulse mem_fetch_redirect for one cycle with mem_fetch_target = bta. This includes misaligned and memory ops.
REQ-016 valid=0 in IDLE SHALL register mem_wb_valid=0 and mem_wb_writeback=0.

Reset
REQ-017 rst SHALL force IDLE immediately and zero all outputs: dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, mem_stall, mem_fetch_redirect, mem_fetch_target, mem_misaligned, and all mem_wb_* outputs.
REQ-018 rst during ACCESS SHALL drop dmem_req asynchronously and discard the op; a late ack after reset SHALL be ignored.

Structure
REQ-019 Package cpu_pkg SHALL hold the mem_state_t enum (IDLE, ACCESS), the mem_size_t enum (BYTE, HALF, WORD) and the byte-enable constants.
REQ-020 Extraction and extension SHALL live in the combinational sub-module load_align (inputs rdata, offset, size, rdu; output 32-bit data).

Verification
REQ-021 Aligned lb: addr 0x1003 -> dmem_addr 0x1000, be 1000. rdata 0x80FFFFFF with ack after 3 wait cycles -> mem_stall high for 4 cycles, then mem_wb_result 0xFFFFFF80.
REQ-022 sh: addr 0x2002, wdata 0x0000BEEF -> dmem_wdata 0xBEEFBEEF, be 1100, we=1. Ack in the first ACCESS cycle -> mem_wb_valid=1, mem_wb_writeback=0.
REQ-023 lw at addr 0x3001 -> no dmem_req, mem_misaligned pulse, no stall, mem_wb_valid=0.
REQ-024 Link op with pc4 0x104 and brnch_taken=1, bta 0x400 -> mem_wb_result 0x104 and a redirect pulse to 0x400 on the same edge; a back-to-back ALU op follows with no bubble.
REQ-025 Assert rst during ACCESS -> dmem_req falls without waiting for a clock edge and outputs are zero. A later ack is ignored and the next op is accepted normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the memory-access stage: FSM states, access
// sizes, byte-enable patterns and the store-lane replication rule.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } mem_size_t;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Word wins over half, half over byte; no size flag at all means word.
    function automatic mem_size_t decode_size(input logic byte_f,
                                              input logic hwrd_f,
                                              input logic wrd_f);
        if (wrd_f)       return WORD;
        else if (hwrd_f) return HALF;
        else if (byte_f) return BYTE;
        else             return WORD;
    endfunction

    // Lane mask for the selected size at the given byte offset.
    function automatic logic [3:0] byte_enable(input mem_size_t size,
                                               input logic [1:0] off);
        case (size)
            BYTE:    return BE_BYTE << off;
            HALF:    return BE_HALF << {off[1], 1'b0};
            default: return BE_WORD;
        endcase
    endfunction

    // Replicate the low store bits across every lane so the byte enables
    // alone select which lanes memory actually writes.
    function automatic logic [DATA_W-1:0] store_lanes(input mem_size_t size,
                                                      input logic [DATA_W-1:0] wdata);
        case (size)
            BYTE:    return {4{wdata[7:0]}};
            HALF:    return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: shifts the addressed lane down to bit 0,
// truncates to the access size and zero- or sign-extends to 32 bits.
module load_align
    import cpu_pkg::*;
(
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        offset,
    input  mem_size_t         size,
    input  logic              rdu,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;

    function automatic logic [DATA_W-1:0] extend_byte(input logic [7:0] b,
                                                      input logic zext);
        logic signed [7:0]        sb;
        logic signed [DATA_W-1:0] wide;
        sb   = b;
        wide = sb;
        return zext ? {24'd0, b} : wide;
    endfunction

    function automatic logic [DATA_W-1:0] extend_half(input logic [15:0] h,
                                                      input logic zext);
        logic signed [15:0]       sh;
        logic signed [DATA_W-1:0] wide;
        sh   = h;
        wide = sh;
        return zext ? {16'd0, h} : wide;
    endfunction

    // Lane extraction followed by size truncation and extension.
    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        case (size)
            BYTE:    data = extend_byte(shifted[7:0], rdu);
            HALF:    data = extend_half(shifted[15:0], rdu);
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage. Non-memory ops pass through in one cycle;
// aligned loads/stores hold the upstream stage while a single request is
// presented to data memory and wait indefinitely for its ack. Misaligned
// ops are dropped with a fault pulse, and taken branches raise a redirect.
module memory_access
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              exec_mem_valid,
    input  logic              exec_mem_writeback,
    input  logic              exec_mem_link,
    input  logic              exec_mem_mem_w,
    input  logic              exec_mem_mem_r,
    input  logic              exec_mem_mem_rdu,
    input  logic              exec_mem_mem_byte,
    input  logic              exec_mem_mem_hwrd,
    input  logic              exec_mem_mem_wrd,
    input  logic [REG_W-1:0]  exec_mem_rd,
    input  logic [DATA_W-1:0] exec_mem_alu_result,
    input  logic [DATA_W-1:0] exec_mem_mem_wdata,
    input  logic [DATA_W-1:0] exec_mem_pc4,
    input  logic              exec_mem_brnch_taken,
    input  logic [DATA_W-1:0] exec_mem_bta,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_be,
    input  logic              dmem_ack,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic              mem_stall,
    output logic              mem_fetch_redirect,
    output logic [DATA_W-1:0] mem_fetch_target,
    output logic              mem_misaligned,
    output logic              mem_wb_valid,
    output logic              mem_wb_writeback,
    output logic [REG_W-1:0]  mem_wb_rd,
    output logic [DATA_W-1:0] mem_wb_result
);

    mem_state_t        state;
    mem_state_t        state_next;

    // Incoming-op decode
    mem_size_t         size_p0;
    logic [1:0]        off_p0;
    logic              is_mem_p0;
    logic              misaligned_p0;
    logic              accept_mem_p0;

    // Op latched for the duration of the access
    mem_size_t         size_p1;
    logic [1:0]        off_p1;
    logic              rdu_p1;
    logic [REG_W-1:0]  rd_p1;
    logic              wb_p1;

    logic [DATA_W-1:0] load_data;

    // Decode size, alignment and whether this op needs the memory port.
    always_comb begin
        size_p0       = decode_size(exec_mem_mem_byte, exec_mem_mem_hwrd, exec_mem_mem_wrd);
        off_p0        = exec_mem_alu_result[1:0];
        is_mem_p0     = exec_mem_valid & (exec_mem_mem_r | exec_mem_mem_w);
        misaligned_p0 = is_mem_p0 &
                        (((size_p0 == HALF) & off_p0[0]) |
                         ((size_p0 == WORD) & (off_p0 != 2'b00)));
        accept_mem_p0 = is_mem_p0 & ~misaligned_p0;
    end

    // State register; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic: enter ACCESS on an aligned memory op, leave on ack.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_mem_p0) state_next = ACCESS;
            ACCESS:  if (dmem_ack)      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Stall upstream from acceptance until the ack cycle; reset forces it low.
    always_comb begin
        mem_stall = 1'b0;
        case (state)
            IDLE:    mem_stall = accept_mem_p0;
            ACCESS:  mem_stall = ~dmem_ack;
            default: mem_stall = 1'b0;
        endcase
        if (rst) mem_stall = 1'b0;
    end

    // Memory request registers: loaded on acceptance, held until ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= '0;
            dmem_wdata <= '0;
            dmem_be    <= '0;
            size_p1    <= WORD;
            off_p1     <= '0;
            rdu_p1     <= 1'b0;
            rd_p1      <= '0;
            wb_p1      <= 1'b0;
        end else if (state == IDLE) begin
            if (accept_mem_p0) begin
                dmem_req   <= 1'b1;
                dmem_we    <= exec_mem_mem_w;
                dmem_addr  <= {exec_mem_alu_result[DATA_W-1:2], 2'b00};
                dmem_be    <= byte_enable(size_p0, off_p0);
                dmem_wdata <= store_lanes(size_p0, exec_mem_mem_wdata);
                size_p1    <= size_p0;
                off_p1     <= off_p0;
                rdu_p1     <= exec_mem_mem_rdu;
                rd_p1      <= exec_mem_rd;
                wb_p1      <= exec_mem_writeback;
            end
        end else if (dmem_ack) begin
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
        end
    end

    load_align u_load_align (
        .rdata  (dmem_rdata),
        .offset (off_p1),
        .size   (size_p1),
        .rdu    (rdu_p1),
        .data   (load_data)
    );

    // Writeback, redirect and fault outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wb_valid       <= 1'b0;
            mem_wb_writeback   <= 1'b0;
            mem_wb_rd          <= '0;
            mem_wb_result      <= '0;
            mem_fetch_redirect <= 1'b0;
            mem_fetch_target   <= '0;
            mem_misaligned     <= 1'b0;
        end else if (state == IDLE) begin
            mem_misaligned     <= misaligned_p0;
            mem_fetch_redirect <= exec_mem_valid & exec_mem_brnch_taken;
            if (exec_mem_valid & exec_mem_brnch_taken)
                mem_fetch_target <= exec_mem_bta;
            if (exec_mem_valid & ~is_mem_p0) begin
                mem_wb_valid     <= 1'b1;
                mem_wb_writeback <= exec_mem_writeback;
                mem_wb_rd        <= exec_mem_rd;
                mem_wb_result    <= exec_mem_link ? exec_mem_pc4 : exec_mem_alu_result;
            end else begin
                mem_wb_valid     <= 1'b0;
                mem_wb_writeback <= 1'b0;
            end
        end else begin
            mem_misaligned     <= 1'b0;
            mem_fetch_redirect <= 1'b0;
            if (dmem_ack) begin
                mem_wb_valid     <= 1'b1;
                mem_wb_writeback <= wb_p1 & ~dmem_we;
                mem_wb_rd        <= rd_p1;
                mem_wb_result    <= dmem_we ? '0 : load_data;
            end else begin
                mem_wb_valid     <= 1'b0;
                mem_wb_writeback <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: single-cycle ops from a vector table, memory ops
// and reset-abort as hand-written sequences, all writeback results checked
// against a queue of expected values.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, wb, link, mw, mr, rdu, sz_b, sz_h, sz_w, taken, ack;
    logic [5:0]  rd;
    logic [31:0] alu, wdata, pc4, bta, rdata;
    logic        dmem_req, dmem_we, mem_stall, mem_fetch_redirect, mem_misaligned;
    logic        mem_wb_valid, mem_wb_writeback;
    logic [31:0] dmem_addr, dmem_wdata, mem_fetch_target, mem_wb_result;
    logic [3:0]  dmem_be;
    logic [5:0]  mem_wb_rd;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        logic        valid, wb, link, mr, mw;
        logic [2:0]  sz;          // {wrd, hwrd, byte}
        logic        taken;
        logic [5:0]  rd;
        logic [31:0] alu, pc4, bta;
        logic        e_vld, e_wb, e_mis, e_red;
        logic [31:0] e_res;
    } vec_t;

    typedef struct {
        logic        vld, wb, mis, red;
        logic [5:0]  rd;
        logic [31:0] res, tgt;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    memory_access dut (
        .clk(clk), .rst(rst),
        .exec_mem_valid(valid), .exec_mem_writeback(wb), .exec_mem_link(link),
        .exec_mem_mem_w(mw), .exec_mem_mem_r(mr), .exec_mem_mem_rdu(rdu),
        .exec_mem_mem_byte(sz_b), .exec_mem_mem_hwrd(sz_h), .exec_mem_mem_wrd(sz_w),
        .exec_mem_rd(rd), .exec_mem_alu_result(alu), .exec_mem_mem_wdata(wdata),
        .exec_mem_pc4(pc4), .exec_mem_brnch_taken(taken), .exec_mem_bta(bta),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ack(ack), .dmem_rdata(rdata),
        .mem_stall(mem_stall), .mem_fetch_redirect(mem_fetch_redirect),
        .mem_fetch_target(mem_fetch_target), .mem_misaligned(mem_misaligned),
        .mem_wb_valid(mem_wb_valid), .mem_wb_writeback(mem_wb_writeback),
        .mem_wb_rd(mem_wb_rd), .mem_wb_result(mem_wb_result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_total++;
            $display("FAIL %s_queue: got empty required entry", tag);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_wbv"}, mem_wb_valid, e.vld);
        chk({tag, "_wbw"}, mem_wb_writeback, e.wb);
        chk({tag, "_mis"}, mem_misaligned, e.mis);
        chk({tag, "_red"}, mem_fetch_redirect, e.red);
        if (e.vld) begin
            chk({tag, "_rd"}, mem_wb_rd, e.rd);
            chk({tag, "_res"}, mem_wb_result, e.res);
        end
        if (e.red) chk({tag, "_tgt"}, mem_fetch_target, e.tgt);
    endtask

    function automatic vec_t mk(logic v, logic w, logic l, logic r, logic s, logic [2:0] sz,
                                logic t, logic [5:0] d, logic [31:0] a, logic [31:0] p,
                                logic [31:0] b, logic ev, logic ew, logic em, logic er,
                                logic [31:0] eres);
        vec_t x;
        x.valid = v; x.wb = w; x.link = l; x.mr = r; x.mw = s; x.sz = sz; x.taken = t;
        x.rd = d; x.alu = a; x.pc4 = p; x.bta = b;
        x.e_vld = ev; x.e_wb = ew; x.e_mis = em; x.e_red = er; x.e_res = eres;
        return x;
    endfunction

    task automatic clear_inputs();
        valid = 0; wb = 0; link = 0; mw = 0; mr = 0; rdu = 0;
        sz_b = 0; sz_h = 0; sz_w = 0; taken = 0;
        rd = '0; alu = '0; wdata = '0; pc4 = '0; bta = '0;
    endtask

    // Aligned memory op: checks request fields, stall length and writeback.
    task automatic mem_op(input string tag, input logic r, input logic s, input logic u,
                          input logic [2:0] sz, input logic [5:0] d, input logic w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic t, input logic [31:0] b,
                          input int waits, input logic [31:0] rdv,
                          input logic [31:0] e_addr, input logic [3:0] e_be,
                          input logic [31:0] e_wd, input logic e_we,
                          input logic [31:0] e_res, input logic e_wb, input int e_stall);
        int   stall_cnt;
        exp_t e;
        stall_cnt = 0;
        valid = 1; mr = r; mw = s; rdu = u; {sz_w, sz_h, sz_b} = sz; rd = d; wb = w;
        alu = a; wdata = wd; taken = t; bta = b; link = 0; ack = 0;
        #1;
        if (mem_stall) stall_cnt++;
        e.vld = 1; e.wb = e_wb; e.mis = 0; e.red = 0; e.rd = d; e.res = e_res; e.tgt = '0;
        sb_q.push_back(e);
        @(posedge clk); #1;
        chk({tag, "_req"}, dmem_req, 1);
        chk({tag, "_addr"}, dmem_addr, e_addr);
        chk({tag, "_be"}, dmem_be, e_be);
        chk({tag, "_wdata"}, dmem_wdata, e_wd);
        chk({tag, "_we"}, dmem_we, e_we);
        chk({tag, "_wbv_acc"}, mem_wb_valid, 0);
        chk({tag, "_red_acc"}, mem_fetch_redirect, t);
        if (t) chk({tag, "_tgt_acc"}, mem_fetch_target, b);
        for (int i = 0; i < waits; i++) begin
            #1;
            if (mem_stall) stall_cnt++;
            @(posedge clk); #1;
            chk({tag, "_req_hold"}, dmem_req, 1);
            chk({tag, "_addr_hold"}, dmem_addr, e_addr);
        end
        ack = 1; rdata = rdv;
        #1;
        if (mem_stall) stall_cnt++;
        @(posedge clk); #1;
        ack = 0; clear_inputs();
        check_out(tag);
        chk({tag, "_req_done"}, dmem_req, 0);
        chk({tag, "_stall_cycles"}, stall_cnt, e_stall);
    endtask

    initial begin
        exp_t e;
        rst = 1; ack = 0; rdata = '0;
        clear_inputs();

        // Single-cycle vectors: {valid,wb,link,mr,mw,{wrd,hwrd,byte},taken,rd,alu,pc4,bta} -> expected
        vecs[0] = mk(0,1,0,0,0,3'b000,0, 6'd1,  32'h11,       32'h0,   32'h0,   0,0,0,0, 32'h0);
        vecs[1] = mk(1,1,0,0,0,3'b000,0, 6'd5,  32'h1234,     32'h8,   32'h0,   1,1,0,0, 32'h1234);
        vecs[2] = mk(1,1,1,0,0,3'b000,1, 6'd31, 32'h55,       32'h104, 32'h400, 1,1,0,1, 32'h104);
        vecs[3] = mk(1,1,0,0,0,3'b000,0, 6'd7,  32'hDEADBEEF, 32'h108, 32'h999, 1,1,0,0, 32'hDEADBEEF);
        vecs[4] = mk(1,1,0,1,0,3'b100,0, 6'd9,  32'h3001,     32'h0,   32'h0,   0,0,1,0, 32'h0);
        vecs[5] = mk(1,1,0,1,0,3'b010,1, 6'd10, 32'h2001,     32'h0,   32'h800, 0,0,1,1, 32'h0);
        vecs[6] = mk(1,0,0,0,1,3'b000,0, 6'd0,  32'h2,        32'h0,   32'h0,   0,0,1,0, 32'h0);
        vecs[7] = mk(1,0,0,0,0,3'b000,0, 6'd63, 32'hCAFE0000, 32'h0,   32'h0,   1,0,0,0, 32'hCAFE0000);
        vecs[8] = mk(1,1,0,1,0,3'b011,0, 6'd4,  32'h7003,     32'h0,   32'h0,   0,0,1,0, 32'h0);
        vecs[9] = mk(1,1,0,1,0,3'b110,0, 6'd4,  32'h7002,     32'h0,   32'h0,   0,0,1,0, 32'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_be", dmem_be, 0);
        chk("rst_stall", mem_stall, 0);
        chk("rst_red", mem_fetch_redirect, 0);
        chk("rst_tgt", mem_fetch_target, 0);
        chk("rst_wbv", mem_wb_valid, 0);
        chk("rst_res", mem_wb_result, 0);
        rst = 0;
        @(posedge clk); #1;

        // Table-driven single-cycle ops, applied back to back
        for (int i = 0; i < 10; i++) begin
            valid = vecs[i].valid; wb = vecs[i].wb; link = vecs[i].link;
            mr = vecs[i].mr; mw = vecs[i].mw; {sz_w, sz_h, sz_b} = vecs[i].sz;
            taken = vecs[i].taken; rd = vecs[i].rd; alu = vecs[i].alu;
            pc4 = vecs[i].pc4; bta = vecs[i].bta; wdata = 32'h0;
            #1;
            chk($sformatf("v%0d_stall", i), mem_stall, 0);
            e.vld = vecs[i].e_vld; e.wb = vecs[i].e_wb; e.mis = vecs[i].e_mis;
            e.red = vecs[i].e_red; e.rd = vecs[i].rd; e.res = vecs[i].e_res; e.tgt = vecs[i].bta;
            sb_q.push_back(e);
            @(posedge clk); #1;
            check_out($sformatf("v%0d", i));
            chk($sformatf("v%0d_noreq", i), dmem_req, 0);
        end
        clear_inputs();
        @(posedge clk); #1;
        chk("mis_pulse_end", mem_misaligned, 0);

        // Memory ops: tag, r, w, rdu, {wrd,hwrd,byte}, rd, wb, addr, wdata, taken, bta,
        //             waits, rdata, e_addr, e_be, e_wdata, e_we, e_res, e_wb, e_stall
        mem_op("lb",  1,0,0, 3'b001, 6'd3,  1, 32'h1003, 32'h0,        0, 32'h0,
               3, 32'h80FFFFFF, 32'h1000, 4'b1000, 32'h0,        0, 32'hFFFFFF80, 1, 4);
        mem_op("sh",  0,1,0, 3'b010, 6'd12, 1, 32'h2002, 32'h0000BEEF, 0, 32'h0,
               0, 32'h12345678, 32'h2000, 4'b1100, 32'hBEEFBEEF, 1, 32'h0,        0, 1);
        mem_op("lhu", 1,0,1, 3'b010, 6'd13, 1, 32'h2002, 32'h0,        1, 32'hA00,
               1, 32'h80011234, 32'h2000, 4'b1100, 32'h0,        0, 32'h00008001, 1, 2);
        mem_op("lh",  1,0,0, 3'b010, 6'd14, 1, 32'h2002, 32'h0,        0, 32'h0,
               0, 32'h80011234, 32'h2000, 4'b1100, 32'h0,        0, 32'hFFFF8001, 1, 1);
        mem_op("lbu", 1,0,1, 3'b001, 6'd15, 1, 32'h1001, 32'h0,        0, 32'h0,
               0, 32'h0000AB00, 32'h1000, 4'b0010, 32'h0,        0, 32'h000000AB, 1, 1);
        mem_op("lb2", 1,0,0, 3'b001, 6'd16, 1, 32'h1002, 32'h0,        0, 32'h0,
               2, 32'h00800000, 32'h1000, 4'b0100, 32'h0,        0, 32'hFFFFFF80, 1, 3);
        mem_op("sb",  0,1,0, 3'b001, 6'd17, 0, 32'h5001, 32'h12345677, 0, 32'h0,
               0, 32'h0,        32'h5000, 4'b0010, 32'h77777777, 1, 32'h0,        0, 1);
        mem_op("rw",  1,1,0, 3'b100, 6'd18, 1, 32'h6000, 32'hA5A50F0F, 0, 32'h0,
               0, 32'hFFFFFFFF, 32'h6000, 4'b1111, 32'hA5A50F0F, 1, 32'h0,        0, 1);
        mem_op("lw",  1,0,0, 3'b100, 6'd19, 1, 32'h7004, 32'h0,        0, 32'h0,
               2, 32'h89ABCDEF, 32'h7004, 4'b1111, 32'h0,        0, 32'h89ABCDEF, 1, 3);

        // Reset in the middle of an access, then a late ack, then a normal op
        valid = 1; mr = 1; sz_w = 1; rd = 6'd20; wb = 1; alu = 32'h40;
        #1;
        @(posedge clk); #1;
        chk("ra_req", dmem_req, 1);
        #2;
        rst = 1;
        #1;
        chk("ra_req_async", dmem_req, 0);
        chk("ra_stall", mem_stall, 0);
        chk("ra_addr", dmem_addr, 0);
        chk("ra_be", dmem_be, 0);
        chk("ra_wbv", mem_wb_valid, 0);
        clear_inputs();
        @(posedge clk); #1;
        rst = 0;
        ack = 1; rdata = 32'hFFFF0000;
        @(posedge clk); #1;
        ack = 0;
        chk("late_ack_wbv", mem_wb_valid, 0);
        chk("late_ack_req", dmem_req, 0);
        mem_op("post", 1,0,0, 3'b100, 6'd21, 1, 32'h44, 32'h0, 0, 32'h0,
               1, 32'h0BADF00D, 32'h44, 4'b1111, 32'h0, 0, 32'h0BADF00D, 1, 2);

        chk("queue_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
